xalu_md: RTL and testbench
==========================

# xalu_md

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the EX stage beside the main ALU. It is driven by the `Start` and `XAluOp` codes produced by the main decoder. It exposes `busy` so hazard logic can stall `mfhi`/`mflo`/`mult`-class instructions while an operation is in flight. This generation generalises the original fixed 32-bit, fixed-latency design: data width and per-operation latency are parameters, and compile-time abort support is optional.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width (≥ 8, even)
- MULT_CYCLES, 5, busy cycles for mult/multu (≥ 1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥ 1)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
- start  input  2  0 none, 1 launch mult/div, 2 move-to-HI/LO, 3 reserved (ignored)
- xaluop  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6–7 ignored
- a  input  WIDTH  rs operand (forwarded value)
- b  input  WIDTH  rt operand (forwarded value)
- abort  input  1  cancel in-flight op; used only with XALU_ABORT_EN
- busy  output  1  operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

## Operation
- State: IDLE, RUN. Counter `cnt` is ceil(log2(max latency+1)) bits wide.
- IDLE, start=1, xaluop∈{0..3}: latch a, b, op; load cnt with MULT_CYCLES or DIV_CYCLES; go to RUN.
- IDLE, start=2, xaluop=4: hi←a. xaluop=5: lo←a. Stay in IDLE. busy stays 0.
- Any other start/xaluop combination in IDLE: no effect.
- RUN: decrement cnt each cycle. When cnt=1, on that edge write HI/LO and go to IDLE.
- In RUN, start is ignored. The hazard unit guarantees no issue while busy; the bench checks that a violation does not corrupt HI/LO.
- Result rules (operands as latched):
  - mult: signed 2·WIDTH product; hi=upper half, lo=lower half.
  - multu: the same, unsigned.
  - div: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Signed -2^(WIDTH-1) / -1: lo=-2^(WIDTH-1), hi=0.
  - Divide by zero (div/divu, b=0): the op runs its full latency; HI/LO are left unchanged.
- Reset (reset=0 at an edge): state=IDLE, cnt=0, hi=0, lo=0, latched operands=0. Reset mid-RUN discards the op with no HI/LO write.

## Timing
- busy is registered: busy = (state==RUN).
- A launch sampled at edge T gives busy=1 for cycles T+1 … T+N, where N is the op latency.
- HI/LO take the new values at edge T+N and are visible in cycle T+N+1, when busy=0.
- A new launch may be sampled at edge T+N+1 at the earliest, i.e. in the first cycle with busy=0.
- mthi/mtlo sampled at edge T are visible at T+1, a 1-cycle latency.
- Reset values: busy=0, hi=0, lo=0.
- No combinational path exists from any input to any output.

## Configuration
- XALU_ABORT_EN defined:
  - abort=1 at an edge while in RUN forces IDLE and cnt=0, with no HI/LO write. busy falls the next cycle.
  - abort in IDLE has priority over start: a same-edge launch or move is dropped.
  - This mechanism exists for exception flush of the EX stage.
- XALU_ABORT_EN undefined: the abort port exists but is ignored; ops always complete.
- reset takes priority over abort in both builds.

## Test plan
- Default parameters, mult a=0xFFFFFFFE (-2), b=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu a=0xFFFFFFFF, b=2 → hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div a=-7, b=2 → after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=100, b=0 with prior hi=0x11, lo=0x22 → busy for 10 cycles; then hi=0x11, lo=0x22 unchanged.
- mthi a=0xDEADBEEF, then mtlo a=5 on consecutive cycles → hi=0xDEADBEEF next cycle, lo=5 the cycle after; busy never asserted. Reset pulse mid-div → busy=0, hi=lo=0 the next cycle.
- With XALU_ABORT_EN defined, mult 7×6, abort on the 3rd busy cycle → busy=0 the next cycle; HI/LO keep pre-op values. Without the macro, the same stimulus → hi=0, lo=42.

Source files
------------

// File: rtl/xalu_md_if.sv
// xalu_md_if: EX-stage bus between decoder/forwarding logic and the multiply/divide unit
//   master drives: start[1:0], xaluop[2:0], a, b, abort
//   slave drives:  busy, hi, lo
interface xalu_md_if #(parameter int WIDTH = 32);
  logic [1:0] start;
  logic [2:0] xaluop;
  logic [WIDTH-1:0] a, b;
  logic abort;
  logic busy;
  logic [WIDTH-1:0] hi, lo;
  modport master (output start, xaluop, a, b, abort, input busy, hi, lo);
  modport slave (input start, xaluop, a, b, abort, output busy, hi, lo);
endinterface

// File: rtl/xalu_md.sv
// xalu_md: multi-cycle multiply/divide unit with architectural HI/LO registers
//   clk, reset (synchronous, active-low); bus (xalu_md_if.slave): start, xaluop, a, b, abort in; busy, hi, lo out
//   XALU_ABORT_EN: when defined, abort cancels an in-flight op and drops a same-edge launch/move
module xalu_md #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic clk,
  input logic reset,
  xalu_md_if.slave bus
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
`ifdef XALU_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] UNIT = {{(WIDTH-1){1'b0}}, 1'b1};
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic [1:0] op, opNext;
  logic [WIDTH-1:0] opA, opB, opANext, opBNext;
  logic [WIDTH-1:0] hiReg, loReg, hiNext, loNext;
  logic signed [2*WIDTH-1:0] prodS;
  logic [2*WIDTH-1:0] prodU;
  logic signed [WIDTH-1:0] dvsS, quoS, remS;
  logic [WIDTH-1:0] dvsU, quoU, remU, resHi, resLo;
  logic kill, ovf, wr;
  assign kill = ABORT_EN && bus.abort;
  assign prodS = $signed({{WIDTH{opA[WIDTH-1]}}, opA}) * $signed({{WIDTH{opB[WIDTH-1]}}, opB});
  assign prodU = {{WIDTH{1'b0}}, opA} * {{WIDTH{1'b0}}, opB};
  // MIN/-1 overflows; dividing by 1 instead yields exactly quotient MIN, remainder 0.
  // A zero divisor is also steered to 1 so the divider never sees it; its result is discarded.
  assign ovf = opA == MIN_NEG && &opB;
  assign dvsS = (opB == '0 || ovf) ? $signed(UNIT) : $signed(opB);
  assign quoS = $signed(opA) / dvsS;
  assign remS = $signed(opA) % dvsS;
  assign dvsU = opB == '0 ? UNIT : opB;
  assign quoU = opA / dvsU;
  assign remU = opA % dvsU;
  assign wr = !(op[1] && opB == '0);
  assign resHi = op == 2'd0 ? prodS[2*WIDTH-1:WIDTH] : op == 2'd1 ? prodU[2*WIDTH-1:WIDTH] :
                 op == 2'd2 ? remS : remU;
  assign resLo = op == 2'd0 ? prodS[WIDTH-1:0] : op == 2'd1 ? prodU[WIDTH-1:0] :
                 op == 2'd2 ? quoS : quoU;
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    opNext = op;
    opANext = opA;
    opBNext = opB;
    hiNext = hiReg;
    loNext = loReg;
    if (state == IDLE) begin
      if (!kill && bus.start == 2'd1 && !bus.xaluop[2]) begin
        stateNext = RUN;
        opNext = bus.xaluop[1:0];
        opANext = bus.a;
        opBNext = bus.b;
        cntNext = bus.xaluop[1] ? DIV_CNT : MULT_CNT;
      end
      hiNext = (!kill && bus.start == 2'd2 && bus.xaluop == 3'd4) ? bus.a : hiReg;
      loNext = (!kill && bus.start == 2'd2 && bus.xaluop == 3'd5) ? bus.a : loReg;
    end else if (kill || cnt == ONE) begin
      stateNext = IDLE;
      cntNext = '0;
      hiNext = (!kill && wr) ? resHi : hiReg;
      loNext = (!kill && wr) ? resLo : loReg;
    end else begin
      cntNext = cnt - ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      opA <= '0;
      opB <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      op <= opNext;
      opA <= opANext;
      opB <= opBNext;
      hiReg <= hiNext;
      loReg <= loNext;
    end
  end
  assign bus.busy = state == RUN;
  assign bus.hi = hiReg;
  assign bus.lo = loReg;
endmodule

// File: tb/tb_xalu_md.sv
// tb_xalu_md: randomized scoreboard bench for xalu_md against an arithmetic reference model
module tb_xalu_md;
  localparam int W = 32, MC = 5, DC = 10;
  localparam int KNONE = 0, KABORT = 1, KRESET = 2;
`ifdef XALU_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  typedef struct {int due; logic [31:0] hi; logic [31:0] lo;} exp_t;
  logic clk = 0;
  logic reset = 0;
  xalu_md_if #(.WIDTH(W)) bus();
  xalu_md #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  int cyc = 0, total = 0, bad = 0, busyFrom = 0, busyTo = -1;
  bit armed = 0, done = 0;
  exp_t scb[$];
  logic [31:0] mHi = 0, mLo = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    logic eb;
    if (armed) begin
      eb = cyc >= busyFrom && cyc <= busyTo;
      total++;
      if (bus.busy !== eb) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, bus.busy, eb);
      end
      while (scb.size() > 0 && scb[0].due <= cyc) begin
        e = scb.pop_front();
        total++;
        if (e.due != cyc || bus.hi !== e.hi || bus.lo !== e.lo) begin
          bad++;
          $display("FAIL hilo cyc=%0d due=%0d got hi=%h lo=%h want hi=%h lo=%h", cyc, e.due, bus.hi, bus.lo, e.hi, e.lo);
        end
      end
      if (done) begin
        total++;
        if (scb.size() != 0) begin
          bad++;
          $display("FAIL drain got=%0d pending want=0", scb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end
  function automatic void calc(input int op, input logic [31:0] a, b, ph, pl, output logic [31:0] h, l);
    int ia, ib;
    longint p, q, r;
    ia = a;
    ib = b;
    h = ph;
    l = pl;
    if (op == 0) begin
      p = longint'(ia) * longint'(ib);
      h = p[63:32];
      l = p[31:0];
    end else if (op == 1) begin
      p = {32'b0, a} * {32'b0, b};
      h = p[63:32];
      l = p[31:0];
    end else if (op == 2 && b != 0) begin
      q = (ia < 0 ? -longint'(ia) : longint'(ia)) / (ib < 0 ? -longint'(ib) : longint'(ib));
      if ((ia < 0) != (ib < 0)) q = -q;
      r = longint'(ia) - q * longint'(ib);
      h = r[31:0];
      l = q[31:0];
    end else if (op == 3 && b != 0) begin
      q = {32'b0, a} / {32'b0, b};
      r = {32'b0, a} - q * {32'b0, b};
      h = r[31:0];
      l = q[31:0];
    end
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction
  task automatic launch(input int op, input logic [31:0] a, b, input int kill, input int at);
    int c, n;
    logic [31:0] h, l, ph, pl;
    @(posedge clk); #1;
    c = cyc;
    n = op < 2 ? MC : DC;
    ph = mHi;
    pl = mLo;
    calc(op, a, b, ph, pl, h, l);
    bus.start = 2'd1; bus.xaluop = 3'(op); bus.a = a; bus.b = b; bus.abort = 0;
    busyFrom = c + 1;
    busyTo = c + n;
    scb.push_back(exp_t'{c + n + 1, h, l});
    mHi = h;
    mLo = l;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      bus.start = 2'($urandom); bus.xaluop = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
      if (i == at && (kill == KRESET || (kill == KABORT && ABORT))) begin
        if (kill == KRESET) reset = 0;
        else bus.abort = 1;
        busyTo = c + i;
        scb.delete(scb.size() - 1);
        mHi = kill == KRESET ? 32'h0 : ph;
        mLo = kill == KRESET ? 32'h0 : pl;
        scb.push_back(exp_t'{c + i + 1, mHi, mLo});
        @(posedge clk); #1;
        reset = 1; bus.abort = 0; bus.start = 0;
        return;
      end
    end
  endtask
  task automatic move(input int op, input logic [31:0] a);
    @(posedge clk); #1;
    bus.start = 2'd2; bus.xaluop = 3'(op); bus.a = a; bus.b = $urandom; bus.abort = 0;
    if (op == 4) mHi = a;
    else mLo = a;
    scb.push_back(exp_t'{cyc + 1, mHi, mLo});
  endtask
  task automatic junk();
    int k;
    k = $urandom_range(0, 3);
    @(posedge clk); #1;
    bus.a = $urandom; bus.b = $urandom; bus.abort = 0;
    bus.start = k == 0 ? 2'd0 : k == 1 ? 2'd3 : k == 2 ? 2'd1 : 2'd2;
    bus.xaluop = k == 2 ? 3'(4 + $urandom_range(0, 3)) : k == 3 ? 3'($urandom_range(0, 5) ^ 4) : 3'($urandom);
    if (k == 3 && bus.xaluop[2:1] == 2'b10) bus.xaluop = 3'd6;
    scb.push_back(exp_t'{cyc + 1, mHi, mLo});
  endtask
  task automatic abortIdle(input logic [31:0] a);
    @(posedge clk); #1;
    bus.start = 2'd2; bus.xaluop = 3'd4; bus.a = a; bus.b = 0; bus.abort = 1;
    if (!ABORT) mHi = a;
    scb.push_back(exp_t'{cyc + 1, mHi, mLo});
  endtask
  initial begin
    int k;
    bus.start = 0; bus.xaluop = 0; bus.a = 0; bus.b = 0; bus.abort = 0;
    repeat (3) @(posedge clk);
    #1;
    scb.push_back(exp_t'{cyc, 32'h0, 32'h0});
    armed = 1;
    reset = 1;
    launch(0, 32'hFFFFFFFE, 32'd3, KNONE, 0);
    launch(1, 32'hFFFFFFFF, 32'd2, KNONE, 0);
    launch(2, -32'sd7, 32'd2, KNONE, 0);
    move(4, 32'h11);
    move(5, 32'h22);
    launch(3, 32'd100, 32'd0, KNONE, 0);
    move(4, 32'hDEADBEEF);
    move(5, 32'd5);
    launch(2, 32'h80000000, 32'hFFFFFFFF, KNONE, 0);
    launch(2, 32'd1234, 32'd7, KRESET, 4);
    launch(0, 32'd7, 32'd6, KABORT, 3);
    abortIdle(32'hCAFEF00D);
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 19);
      if (k < 12) launch($urandom_range(0, 3), pick(), pick(), k == 0 ? KABORT : k == 1 ? KRESET : KNONE, $urandom_range(1, MC));
      else if (k < 15) move($urandom_range(4, 5), $urandom);
      else if (k < 18) junk();
      else abortIdle($urandom);
    end
    @(posedge clk); #1;
    bus.start = 0; bus.abort = 0;
    repeat (3) @(posedge clk);
    #1;
    done = 1;
    repeat (5) @(posedge clk);
    $display("FAIL timeout got=no summary want=summary");
    $fatal(1);
  end
endmodule
